// File: rtl/region_pkg.sv
// Shared types and default geometry for region_highlighter and its region FSMs.
package region_pkg;

  // Per-region lifecycle: waiting, counting flagged frames, lit, and lit-after-flag-drop.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArming = 2'd1,
    StActive = 2'd2,
    StHold   = 2'd3
  } region_state_e;

  localparam int unsigned DEFAULT_H_RES = 640;
  localparam int unsigned DEFAULT_V_RES = 480;

endpackage

// File: rtl/region_fsm.sv
// One region's debounce/hold state machine. Advances only on frame-start samples.
module region_fsm
  import region_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_sample,
  input  logic          i_flag,
  output region_state_e o_state,
  output logic          o_lit
);

  region_state_e r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_hold;
  logic          r_lit;

  // State, counters and the lit flag all move together on a sampled frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_hold  <= 8'd0;
      r_lit   <= 1'b0;
    end else if (i_sample) begin
      unique case (r_state)
        StIdle: begin
          if (i_flag) begin
            if (DEBOUNCE_FRAMES == 1) begin
              r_state <= StActive;
              r_lit   <= 1'b1;
            end else begin
              r_state <= StArming;
              r_cnt   <= 4'd1;
            end
          end
        end
        StArming: begin
          if (!i_flag) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
          end else if (r_cnt + 4'd1 == 4'(DEBOUNCE_FRAMES)) begin
            r_state <= StActive;
            r_cnt   <= 4'd0;
            r_lit   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StActive: begin
          if (!i_flag) begin
            if (HOLD_FRAMES == 0) begin
              r_state <= StIdle;
              r_lit   <= 1'b0;
            end else begin
              r_state <= StHold;
              r_hold  <= 8'(HOLD_FRAMES);
            end
          end
        end
        StHold: begin
          if (i_flag) begin
            r_state <= StActive;
            r_hold  <= 8'd0;
          end else if (r_hold == 8'd1) begin
            // Last hold frame consumed.
            r_state <= StIdle;
            r_hold  <= 8'd0;
            r_lit   <= 1'b0;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 4'd0;
          r_hold  <= 8'd0;
          r_lit   <= 1'b0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_lit   = r_lit;

endmodule

// File: rtl/region_highlighter.sv
// Splits the active picture into N_REGIONS vertical strips, debounces per-strip flags
// across frames and draws a filled or outlined rectangle over lit strips.
// Optional macro REGION_HIGHLIGHTER_BLINK_EN: regions in hold blink with frame counter bit 2.
module region_highlighter
  import region_pkg::*;
#(
  parameter int unsigned N_REGIONS       = 4,
  parameter int unsigned H_RES           = DEFAULT_H_RES,
  parameter int unsigned V_RES           = DEFAULT_V_RES,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES     = 8,
  parameter int unsigned BORDER_PX       = 0
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [9:0]                                          x_pos,
  input  logic [9:0]                                          y_pos,
  input  logic                                                frame_start,
  input  logic [N_REGIONS-1:0]                                flags,
  output logic                                                highlight,
  output logic [((N_REGIONS > 1) ? $clog2(N_REGIONS) : 1)-1:0] region_idx,
  output logic [N_REGIONS-1:0]                                active_mask
);

  localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned W     = H_RES / N_REGIONS;

  logic [31:0]       w_x;
  logic [31:0]       w_y;
  logic              w_y_ok;
  logic              w_blink_on;
  region_state_e     w_state [N_REGIONS];
  logic [31:0]       w_off   [N_REGIONS];
  logic [N_REGIONS-1:0] w_hit;
  logic [N_REGIONS-1:0] w_drawn;
  logic [N_REGIONS-1:0] w_edge;
  logic              w_hl_d;
  logic [IDX_W-1:0]  w_idx_d;
  logic              r_highlight;
  logic [IDX_W-1:0]  r_region_idx;

  assign w_x    = {22'd0, x_pos};
  assign w_y    = {22'd0, y_pos};
  assign w_y_ok = (w_y < V_RES);

`ifdef REGION_HIGHLIGHTER_BLINK_EN
  logic [3:0] r_frame_cnt;

  // Free-running frame counter; bit 2 gates hold-state drawing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 4'd0;
    end else if (frame_start) begin
      r_frame_cnt <= r_frame_cnt + 4'd1;
    end
  end

  assign w_blink_on = r_frame_cnt[2];
`else
  assign w_blink_on = 1'b1;
`endif

  for (genvar k = 0; k < N_REGIONS; k++) begin : g_region
    localparam int unsigned Lo = k * W;

    region_fsm #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
      .HOLD_FRAMES     (HOLD_FRAMES)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sample (frame_start),
      .i_flag   (flags[k]),
      .o_state  (w_state[k]),
      .o_lit    (active_mask[k])
    );

    // Offset wraps for x left of the strip, so a single compare covers both bounds.
    assign w_off[k]   = w_x - Lo;
    assign w_hit[k]   = (w_off[k] < W);
    assign w_drawn[k] = (w_state[k] == StActive) || ((w_state[k] == StHold) && w_blink_on);

    if (BORDER_PX == 0) begin : g_fill
      assign w_edge[k] = 1'b1;
    end else begin : g_outline
      assign w_edge[k] = (w_off[k] < BORDER_PX) || (w_off[k] >= W - BORDER_PX) ||
                         (w_y < BORDER_PX) || (w_y >= V_RES - BORDER_PX);
    end
  end

  // Pixel decode against current (pre-update) region states.
  always_comb begin
    w_hl_d  = 1'b0;
    w_idx_d = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      if (w_y_ok && w_hit[k]) begin
        w_idx_d = IDX_W'(k);
        w_hl_d  = w_drawn[k] && w_edge[k];
      end
    end
  end

  // One-cycle registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_highlight  <= 1'b0;
      r_region_idx <= '0;
    end else begin
      r_highlight  <= w_hl_d;
      r_region_idx <= w_idx_d;
    end
  end

  assign highlight  = r_highlight;
  assign region_idx = r_region_idx;

endmodule

// File: tb/tb_region_highlighter.sv
// Randomized + directed bench for region_highlighter against a frame-level reference model.
module tb_region_highlighter;

  localparam int N    = 4;
  localparam int HR   = 640;
  localparam int VR   = 480;
  localparam int W    = HR / N;
  localparam int DEB  = 3;
  localparam int HOLD = 8;
  localparam int BP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       frame_start = 1'b0;
  logic [3:0] flags = '0;
  logic       hl, hl_b;
  logic [1:0] idx, idx_b;
  logic [3:0] mask, mask_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: consecutive flagged frames, consecutive unflagged frames since lit.
  int streak [N];
  int zeros  [N];
  bit lit    [N];
  int fc;

  always #5 clk = ~clk;

  region_highlighter #(
    .N_REGIONS(N), .H_RES(HR), .V_RES(VR), .DEBOUNCE_FRAMES(DEB), .HOLD_FRAMES(HOLD),
    .BORDER_PX(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
    .flags(flags), .highlight(hl), .region_idx(idx), .active_mask(mask)
  );

  region_highlighter #(
    .N_REGIONS(N), .H_RES(HR), .V_RES(VR), .DEBOUNCE_FRAMES(DEB), .HOLD_FRAMES(HOLD),
    .BORDER_PX(BP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
    .flags(flags), .highlight(hl_b), .region_idx(idx_b), .active_mask(mask_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      streak[k] = 0;
      zeros[k]  = 0;
      lit[k]    = 1'b0;
    end
    fc = 0;
  endfunction

  function automatic void model_update(input logic [3:0] fl);
    for (int k = 0; k < N; k++) begin
      if (fl[k]) begin
        streak[k]++;
        zeros[k] = 0;
        if (streak[k] >= DEB) lit[k] = 1'b1;
      end else begin
        streak[k] = 0;
        if (lit[k]) begin
          zeros[k]++;
          if (zeros[k] > HOLD) begin
            lit[k]   = 1'b0;
            zeros[k] = 0;
          end
        end
      end
    end
    fc = (fc + 1) % 16;
  endfunction

  function automatic logic [3:0] model_mask();
    logic [3:0] m;
    for (int k = 0; k < N; k++) m[k] = lit[k];
    return m;
  endfunction

  function automatic void exp_pix(input int x, input int y, input int bp,
                                  output bit e_hl, output int e_idx);
    int k, off;
    bit blink, drawn, on_edge;
`ifdef REGION_HIGHLIGHTER_BLINK_EN
    blink = ((fc / 4) % 2) == 1;
`else
    blink = 1'b1;
`endif
    e_hl  = 1'b0;
    e_idx = 0;
    if (x < N * W && y < VR) begin
      k       = x / W;
      off     = x % W;
      e_idx   = k;
      drawn   = lit[k] && (zeros[k] == 0 || blink);
      on_edge = (bp == 0) || (off < bp) || (off >= W - bp) || (y < bp) || (y >= VR - bp);
      e_hl    = drawn && on_edge;
    end
  endfunction

  // One clock: drive a pixel (and optionally a frame start), then check one cycle later.
  task automatic step(input int x, input int y, input bit fs, input logic [3:0] fl);
    bit e_hl, e_hlb;
    int e_idx, e_idxb;
    @(negedge clk);
    x_pos       = 10'(x);
    y_pos       = 10'(y);
    frame_start = fs;
    flags       = fl;
    exp_pix(x, y, 0, e_hl, e_idx);
    exp_pix(x, y, BP, e_hlb, e_idxb);
    @(posedge clk);
    #1;
    if (fs) model_update(fl);
    check("highlight", 32'(hl), 32'(e_hl));
    check("region_idx", 32'(idx), 32'(e_idx));
    check("highlight_border", 32'(hl_b), 32'(e_hlb));
    check("region_idx_border", 32'(idx_b), 32'(e_idxb));
    check("active_mask", 32'(mask), 32'(model_mask()));
    check("active_mask_border", 32'(mask_b), 32'(model_mask()));
  endtask

  task automatic frame(input logic [3:0] fl);
    step($urandom_range(0, 700), $urandom_range(0, 500), 1'b0, fl);
    step($urandom_range(0, 700), $urandom_range(0, 500), 1'b1, fl);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_highlight", 32'(hl), 32'd0);
    check("rst_region_idx", 32'(idx), 32'd0);
    check("rst_mask", 32'(mask), 32'd0);
    check("rst_highlight_border", 32'(hl_b), 32'd0);
    model_reset();
    frame_start = 1'b0;
    flags       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] base;
    model_reset();
    #12;
    check("reset_highlight", 32'(hl), 32'd0);
    check("reset_region_idx", 32'(idx), 32'd0);
    check("reset_mask", 32'(mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three flagged frames light region 0.
    for (int i = 0; i < 3; i++) frame(4'b0001);
    check("r35_mask", 32'(mask), 32'h1);
    step(100, 200, 1'b0, 4'b0000);
    check("r35_hl", 32'(hl), 32'd1);
    check("r35_idx", 32'(idx), 32'd0);

    // Two flagged frames are not enough.
    do_reset();
    frame(4'b0010);
    frame(4'b0010);
    frame(4'b0000);
    check("r36_mask", 32'(mask), 32'h0);
    step(200, 10, 1'b0, 4'b0000);
    check("r36_hl", 32'(hl), 32'd0);

    // Hold length, then re-flag during hold.
    do_reset();
    for (int i = 0; i < 3; i++) frame(4'b0100);
    for (int i = 1; i <= 9; i++) begin
      frame(4'b0000);
      check("r37_hold", 32'(mask[2]), (i <= 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) frame(4'b0100);
    for (int i = 0; i < 4; i++) frame(4'b0000);
    for (int i = 0; i < 10; i++) begin
      frame(4'b0100);
      check("r37_relit", 32'(mask[2]), 32'd1);
    end

    // Outline drawing on region 1.
    do_reset();
    for (int i = 0; i < 3; i++) frame(4'b0010);
    step(160, 100, 1'b0, 4'b0000);
    check("r38_left", 32'(hl_b), 32'd1);
    step(319, 100, 1'b0, 4'b0000);
    check("r38_right", 32'(hl_b), 32'd1);
    step(240, 100, 1'b0, 4'b0000);
    check("r38_inner", 32'(hl_b), 32'd0);
    step(240, 479, 1'b0, 4'b0000);
    check("r38_bottom", 32'(hl_b), 32'd1);

    // Reset in the middle of a hold on region 3.
    do_reset();
    for (int i = 0; i < 3; i++) frame(4'b1000);
    frame(4'b0000);
    frame(4'b0000);
    step(600, 10, 1'b0, 4'b0000);
    do_reset();
    frame(4'b1000);
    frame(4'b1000);
    check("r39_not_yet", 32'(mask[3]), 32'd0);
    frame(4'b1000);
    check("r39_relit", 32'(mask[3]), 32'd1);
    step(650, 10, 1'b0, 4'b0000);
    check("r39_out_hl", 32'(hl), 32'd0);
    check("r39_out_idx", 32'(idx), 32'd0);

    // Random flag runs and pixels, including pixels on frame-start cycles.
    base = '0;
    for (int f = 0; f < 400; f++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 99) < 20) base[k] = ~base[k];
      for (int p = 0; p < 4; p++) begin
        int y;
        case ($urandom_range(0, 3))
          0:       y = $urandom_range(0, 3);
          1:       y = $urandom_range(470, 530);
          default: y = $urandom_range(0, 479);
        endcase
        step($urandom_range(0, 1023), y, 1'b0, 4'($urandom));
      end
      step($urandom_range(0, 700), $urandom_range(0, 479), 1'b1, base);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
